// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and width helpers for the instruction prefetch queue.
package instr_prefetch_queue_pkg;

  localparam int unsigned IPQ_DEPTH   = 4;
  localparam int unsigned INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ipq_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Fetch request, memory response, core output and redirect channels of the prefetch queue.
interface instr_prefetch_queue_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Queue side.
  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_instr,
    input  req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
  );

  // Memory / core side.
  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_instr,
    output req_ready, resp_valid, resp_data, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; head is read straight from storage.
module instr_prefetch_queue_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IPQ_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_push,
  input  ipq_entry_t                i_data,
  input  logic                      i_pop,
  output ipq_entry_t                o_data,
  output logic                      o_valid,
  output logic [cnt_w(DEPTH)-1:0]   o_occ
);

  localparam int unsigned PtrW = ptr_w(DEPTH);
  localparam int unsigned CntW = cnt_w(DEPTH);

  ipq_entry_t      r_mem [DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_cnt;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;

  assign w_full  = (r_cnt == CntW'(DEPTH));
  assign w_pop   = i_pop && (r_cnt != '0);
  assign w_wr_en = i_push && !rst && !i_flush;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      // Push into a full FIFO is only legal when the head leaves in the same cycle.
      assert (!(i_push && w_full && !w_pop));
      if (i_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_cnt <= r_cnt + CntW'(i_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_cnt != '0);
  assign o_occ   = r_cnt;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher with redirect flush; optional counters under IPQ_STATS_EN.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = IPQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_prefetch_queue_if.master bus
`ifdef IPQ_STATS_EN
  ,
  output logic [15:0]            stat_flushes,
  output logic [15:0]            stat_dropped
`endif
);

  localparam int unsigned CntW   = cnt_w(DEPTH);
  localparam logic [CntW:0] DepthW = (CntW + 1)'(DEPTH);
  localparam logic [31:0] PcStep = 32'(INSTR_BYTES);

  logic [31:0]     r_fetch_pc;
  logic [31:0]     r_resp_pc;
  logic [CntW-1:0] r_live_cnt;
  logic [CntW-1:0] r_stale_cnt;

  logic [CntW-1:0] w_occ;
  logic [CntW:0]   w_fill;
  logic [CntW:0]   w_inflight;
  logic            w_fifo_valid;
  logic            w_req_fire;
  logic            w_resp_any;
  logic            w_resp_live;
  logic            w_resp_stale;
  logic            w_pop;
  logic [31:0]     w_target;
  ipq_entry_t      w_push_data;
  ipq_entry_t      w_head;

  // Two credits: FIFO space for live responses, and total outstanding memory requests.
  assign w_fill     = {1'b0, w_occ} + {1'b0, r_live_cnt};
  assign w_inflight = {1'b0, r_live_cnt} + {1'b0, r_stale_cnt};

  assign bus.req_valid = !rst && !bus.redirect_valid && (w_fill < DepthW) && (w_inflight < DepthW);
  assign bus.req_addr  = r_fetch_pc;
  assign w_req_fire    = bus.req_valid && bus.req_ready;

  assign w_resp_any   = bus.resp_valid && ((r_live_cnt != '0) || (r_stale_cnt != '0));
  assign w_resp_stale = bus.resp_valid && (r_stale_cnt != '0);
  assign w_resp_live  = w_resp_any && (r_stale_cnt == '0) && !bus.redirect_valid;

  assign w_target    = word_align(bus.redirect_pc);
  assign w_push_data = '{pc: r_resp_pc, instr: bus.resp_data};

  assign bus.out_valid = w_fifo_valid && !rst;
  assign bus.out_pc    = w_head.pc;
  assign bus.out_instr = w_head.instr;
  assign w_pop         = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_resp_pc   <= RESET_PC;
      r_live_cnt  <= '0;
      r_stale_cnt <= '0;
    end else if (bus.redirect_valid) begin
      // Every outstanding request becomes stale; a same-cycle response retires one of them.
      r_fetch_pc  <= w_target;
      r_resp_pc   <= w_target;
      r_live_cnt  <= '0;
      r_stale_cnt <= r_stale_cnt + r_live_cnt - CntW'(w_resp_any);
    end else begin
      if (w_req_fire)  r_fetch_pc <= r_fetch_pc + PcStep;
      if (w_resp_live) r_resp_pc  <= r_resp_pc + PcStep;
      r_live_cnt  <= r_live_cnt + CntW'(w_req_fire) - CntW'(w_resp_live);
      r_stale_cnt <= r_stale_cnt - CntW'(w_resp_stale);
    end
  end

  instr_prefetch_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_resp_live),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_valid (w_fifo_valid),
    .o_occ   (w_occ)
  );

`ifdef IPQ_STATS_EN
  logic [15:0] r_flushes;
  logic [15:0] r_dropped;
  logic        w_drop;

  assign w_drop = bus.resp_valid && ((r_stale_cnt != '0) || bus.redirect_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flushes <= '0;
      r_dropped <= '0;
    end else begin
      if (bus.redirect_valid && (r_flushes != 16'hFFFF)) r_flushes <= r_flushes + 16'd1;
      if (w_drop && (r_dropped != 16'hFFFF))             r_dropped <= r_dropped + 16'd1;
    end
  end

  assign stat_flushes = r_flushes;
  assign stat_dropped = r_dropped;
`endif

endmodule
